register_bank_ctx: RTL and testbench
====================================

Name: register_bank_ctx

Overview:
- Parametrised successor to the 8x8 register_bank: configurable width and register count, with a dedicated write selector and two combinational read ports (rx, ry).
- Adds an asynchronous active-low reset that clears all state.
- Adds a hardware context stack: a single cycle saves or restores the whole register array, for interrupt/call entry and exit in the CPU datapath.
- Sits between decode (selectors) and the ALU (operands); results write back through in_data.

Parameters:
- DATA_W, 8, bit width of each register.
- NUM_REGS, 8, number of registers; power of two, >=2.
- SEL_W, $clog2(NUM_REGS), selector width (derived, do not override).
- CTX_DEPTH, 4, number of context-stack entries; >=1.
- PTR_W, $clog2(CTX_DEPTH+1), stack-depth counter width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_en  in  1  write in_data to register in_wr_selector at the next rising edge.
- in_wr_selector  in  SEL_W  write address.
- in_rx_selector  in  SEL_W  read address, port rx.
- in_ry_selector  in  SEL_W  read address, port ry.
- in_data  in  DATA_W  write data.
- out_rx_data  out  DATA_W  regs[in_rx_selector], combinational.
- out_ry_data  out  DATA_W  regs[in_ry_selector], combinational.
- ctx_push  in  1  save all registers to the stack.
- ctx_pop  in  1  restore all registers from the stack.
- err_clr  in  1  clear out_err.
- out_ctx_depth  out  PTR_W  number of saved contexts.
- out_ctx_full  out  1  out_ctx_depth == CTX_DEPTH.
- out_ctx_empty  out  1  out_ctx_depth == 0.
- out_err  out  1  sticky stack-misuse flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers, stack entries, depth and out_err go to 0;
  - out_ctx_empty=1, out_ctx_full=0, outputs read 0.
  - A reset asserted mid-push/pop abandons the operation; state is fully 0.
- Reads:
  - combinational from the current array; no write bypass;
  - a written value is visible on the read ports after the write edge;
  - rx and ry may address the same register.
- Write:
  - on a rising edge with write_en=1, regs[in_wr_selector] <= in_data;
  - write to an address == a read address shows the new value after the edge.
- Push, accepted when ctx_push=1, ctx_pop=0 and not full:
  - stack[depth] <= all regs (pre-edge values, i.e. excluding a same-cycle write);
  - depth <= depth+1;
  - a same-cycle write still updates the live array.
- Pop, accepted when ctx_pop=1, ctx_push=0 and not empty:
  - all regs <= stack[depth-1]; depth <= depth-1;
  - a same-cycle write_en is applied after the restore, so the written register takes in_data and all others take their saved values.
- Errors (out_err <= 1, stack and depth unchanged; a same-cycle write_en still applies):
  - push when full;
  - pop when empty;
  - ctx_push and ctx_pop high together.
- out_err:
  - stays set until err_clr=1 at an edge;
  - if err_clr and a new error occur in the same cycle, the error wins (out_err stays 1).
- Flags and depth are registered; they update on the same edge as the operation.
- Stack entries above depth keep stale data; they are never readable.

Optional Feature:
- Macro: REG_ZERO_HARDWIRED_EN.
- Defined:
  - register 0 always reads 0 on both ports;
  - writes to selector 0 are ignored;
  - register 0 is pushed as 0 and restored as 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package register_bank_pkg: default DATA_W, NUM_REGS and CTX_DEPTH constants, plus a reg_ctx_t typedef (packed array of NUM_REGS x DATA_W) used for the stack entries.
- One natural sub-module, ctx_stack_ctrl: owns depth, full, empty and out_err, and produces push_ok and pop_ok.
- register_bank_ctx holds the array and the stack storage.

Test Plan:
- Reset then write/read: reset; write 8'hAA to r4, then 8'hFF to r1; set rx=4, ry=1 -> out_rx_data=8'hAA, out_ry_data=8'hFF; other registers read 0.
- Push/pop round trip:
  - r2=8'h11, push (depth 1), write r2=8'h22 -> reads 8'h22;
  - pop -> r2 reads 8'h11; depth 0, empty=1.
- Fill and overflow (CTX_DEPTH=4):
  - four pushes -> full=1, depth=4;
  - a fifth push -> out_err=1, depth stays 4, contents unchanged;
  - err_clr -> out_err=0.
- Underflow and conflict:
  - pop when empty -> out_err=1, registers unchanged;
  - push+pop together at depth 1 -> out_err=1, depth stays 1.
- Simultaneous ops:
  - r3=8'h05, push with write r3=8'h09 same cycle -> live r3=8'h09; later pop restores 8'h05;
  - pop with write r3=8'h7E -> r3=8'h7E, others take their saved values.
- Async reset mid-stack: at depth 3, pull rst_n low between edges -> depth=0, all reads 0 immediately; with REG_ZERO_HARDWIRED_EN, a write of 8'hFF to r0 reads 0.

Source files
------------

// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - shared constants and context type for the register bank
//
// Purpose: default geometry of the register bank and its context stack, and
//          the packed whole-array context type used for stack entries.
// Ports:   none (package).
package register_bank_pkg;

  localparam int DEFAULT_DATA_W    = 8;
  localparam int DEFAULT_NUM_REGS  = 8;
  localparam int DEFAULT_CTX_DEPTH = 4;

  // One saved context: every register of the array, register 0 in the low slot.
  typedef logic [DEFAULT_NUM_REGS-1:0][DEFAULT_DATA_W-1:0] reg_ctx_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int ctx_ptr_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ctx_stack_ctrl.sv
// rtl/ctx_stack_ctrl.sv - context-stack depth tracking, flags and misuse detection
//
// Purpose: decides whether a push or pop request is accepted this cycle, keeps
//          the number of saved contexts and the registered full/empty flags,
//          and holds the sticky misuse flag.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ctx_push  in   save request
//   ctx_pop   in   restore request
//   err_clr   in   clear the sticky error flag
//   push_ok   out  push accepted this cycle (write stack[depth])
//   pop_ok    out  pop accepted this cycle (restore from stack[depth-1])
//   depth     out  number of saved contexts
//   full      out  depth == CTX_DEPTH
//   empty     out  depth == 0
//   err       out  sticky misuse flag
module ctx_stack_ctrl
  import register_bank_pkg::*;
#(
  parameter int CTX_DEPTH = DEFAULT_CTX_DEPTH,
  parameter int PTR_W     = ctx_ptr_w(CTX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctx_push,
  input  logic             ctx_pop,
  input  logic             err_clr,
  output logic             push_ok,
  output logic             pop_ok,
  output logic [PTR_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             err
);

  logic [PTR_W-1:0] depth_q, depth_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;
  logic             err_evt;

  // A request is accepted only when it is the sole request and the stack
  // can serve it; every other requesting combination is misuse.
  assign push_ok = ctx_push & ~ctx_pop & ~full_q;
  assign pop_ok  = ctx_pop & ~ctx_push & ~empty_q;
  assign err_evt = (ctx_push | ctx_pop) & ~push_ok & ~pop_ok;

  always_comb begin
    depth_d = depth_q;
    if (push_ok) begin
      depth_d = depth_q + PTR_W'(1);
    end else if (pop_ok) begin
      depth_d = depth_q - PTR_W'(1);
    end
    full_d  = (depth_d == PTR_W'(CTX_DEPTH));
    empty_d = (depth_d == '0);
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (err_evt) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign depth = depth_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

endmodule

// File: rtl/register_bank_ctx.sv
// rtl/register_bank_ctx.sv - parametrised register bank with single-cycle context stack
//
// Purpose: register array with one write port and two combinational read
//          ports, plus a stack that saves or restores the whole array in one
//          cycle for interrupt/call entry and exit.
// Optional feature: define REG_ZERO_HARDWIRED_EN to make register 0 a
//          constant zero (reads 0, writes ignored, saved and restored as 0).
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset, clears all state
//   write_en       in   write in_data to regs[in_wr_selector]
//   in_wr_selector in   write address
//   in_rx_selector in   read address, port rx
//   in_ry_selector in   read address, port ry
//   in_data        in   write data
//   out_rx_data    out  regs[in_rx_selector], combinational
//   out_ry_data    out  regs[in_ry_selector], combinational
//   ctx_push       in   save all registers to the stack
//   ctx_pop        in   restore all registers from the stack
//   err_clr        in   clear out_err
//   out_ctx_depth  out  number of saved contexts
//   out_ctx_full   out  stack full
//   out_ctx_empty  out  stack empty
//   out_err        out  sticky stack-misuse flag
module register_bank_ctx
  import register_bank_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_REGS  = DEFAULT_NUM_REGS,
  parameter int SEL_W     = $clog2(NUM_REGS),
  parameter int CTX_DEPTH = DEFAULT_CTX_DEPTH,
  parameter int PTR_W     = ctx_ptr_w(CTX_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [SEL_W-1:0]  in_wr_selector,
  input  logic [SEL_W-1:0]  in_rx_selector,
  input  logic [SEL_W-1:0]  in_ry_selector,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_rx_data,
  output logic [DATA_W-1:0] out_ry_data,
  input  logic              ctx_push,
  input  logic              ctx_pop,
  input  logic              err_clr,
  output logic [PTR_W-1:0]  out_ctx_depth,
  output logic              out_ctx_full,
  output logic              out_ctx_empty,
  output logic              out_err
);

  // Index width for the stack storage itself (entries 0..CTX_DEPTH-1).
  localparam int IDX_W = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] ctx_t;

  ctx_t             regs_q, regs_d;
  ctx_t             stack_q [CTX_DEPTH];
  logic             push_ok, pop_ok;
  logic [PTR_W-1:0] depth;
  logic [IDX_W-1:0] push_idx, pop_idx;

  ctx_stack_ctrl #(
    .CTX_DEPTH (CTX_DEPTH),
    .PTR_W     (PTR_W)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctx_push (ctx_push),
    .ctx_pop  (ctx_pop),
    .err_clr  (err_clr),
    .push_ok  (push_ok),
    .pop_ok   (pop_ok),
    .depth    (depth),
    .full     (out_ctx_full),
    .empty    (out_ctx_empty),
    .err      (out_err)
  );

  // A push only happens below full, so depth fits the storage index; a pop
  // only happens above empty, and modular subtraction in the low bits gives
  // depth-1 even when depth equals a power-of-two CTX_DEPTH.
  assign push_idx = depth[IDX_W-1:0];
  assign pop_idx  = depth[IDX_W-1:0] - IDX_W'(1);

  // Restore first, then the same-cycle write lands on top of it.
  always_comb begin
    regs_d = regs_q;
    if (pop_ok) begin
      regs_d = stack_q[pop_idx];
    end
    if (write_en) begin
      regs_d[in_wr_selector] = in_data;
    end
`ifdef REG_ZERO_HARDWIRED_EN
    regs_d[0] = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // The snapshot is the pre-edge array, so a same-cycle write is not saved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CTX_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (push_ok) begin
      stack_q[push_idx] <= regs_q;
    end
  end

`ifdef REG_ZERO_HARDWIRED_EN
  assign out_rx_data = (in_rx_selector == '0) ? '0 : regs_q[in_rx_selector];
  assign out_ry_data = (in_ry_selector == '0) ? '0 : regs_q[in_ry_selector];
`else
  assign out_rx_data = regs_q[in_rx_selector];
  assign out_ry_data = regs_q[in_ry_selector];
`endif

  assign out_ctx_depth = depth;

endmodule

// File: tb/tb_register_bank_ctx.sv
// tb/tb_register_bank_ctx.sv - directed table-driven bench for register_bank_ctx
module tb_register_bank_ctx;

  logic       clk;
  logic       rst_n;
  logic       write_en;
  logic [2:0] in_wr_selector;
  logic [2:0] in_rx_selector;
  logic [2:0] in_ry_selector;
  logic [7:0] in_data;
  logic [7:0] out_rx_data;
  logic [7:0] out_ry_data;
  logic       ctx_push;
  logic       ctx_pop;
  logic       err_clr;
  logic [2:0] out_ctx_depth;
  logic       out_ctx_full;
  logic       out_ctx_empty;
  logic       out_err;

  int checks   = 0;
  int failures = 0;

`ifdef REG_ZERO_HARDWIRED_EN
  localparam logic [7:0] R0V = 8'h00;
`else
  localparam logic [7:0] R0V = 8'hFF;
`endif

  register_bank_ctx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .write_en       (write_en),
    .in_wr_selector (in_wr_selector),
    .in_rx_selector (in_rx_selector),
    .in_ry_selector (in_ry_selector),
    .in_data        (in_data),
    .out_rx_data    (out_rx_data),
    .out_ry_data    (out_ry_data),
    .ctx_push       (ctx_push),
    .ctx_pop        (ctx_pop),
    .err_clr        (err_clr),
    .out_ctx_depth  (out_ctx_depth),
    .out_ctx_full   (out_ctx_full),
    .out_ctx_empty  (out_ctx_empty),
    .out_err        (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] ws;
    logic [7:0] d;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] erx;
    logic [7:0] ery;
    logic [2:0] edep;
    logic       efull;
    logic       eempty;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [2:0] ws, logic [7:0] d,
                              logic [2:0] rx, logic [2:0] ry,
                              logic push, logic pop, logic clr,
                              logic [7:0] erx, logic [7:0] ery, logic [2:0] edep,
                              logic efull, logic eempty, logic eerr);
    vec_t v;
    v.we = we; v.ws = ws; v.d = d; v.rx = rx; v.ry = ry;
    v.push = push; v.pop = pop; v.clr = clr;
    v.erx = erx; v.ery = ery; v.edep = edep;
    v.efull = efull; v.eempty = eempty; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic idle();
    write_en = 1'b0; in_wr_selector = '0; in_data = '0;
    ctx_push = 1'b0; ctx_pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check_flags(input string tag, input int row, input logic [2:0] dep,
                             input logic f, input logic e, input logic er);
    chk({tag, "_depth"}, row, 32'(out_ctx_depth), 32'(dep));
    chk({tag, "_full"},  row, 32'(out_ctx_full),  32'(f));
    chk({tag, "_empty"}, row, 32'(out_ctx_empty), 32'(e));
    chk({tag, "_err"},   row, 32'(out_err),       32'(er));
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 8; s++) begin
      in_rx_selector = 3'(s);
      in_ry_selector = 3'(7 - s);
      #1;
      chk({tag, "_rx"}, s, 32'(out_rx_data), 32'h0);
      chk({tag, "_ry"}, s, 32'(out_ry_data), 32'h0);
    end
  endtask

  initial begin
    //          we ws  d      rx ry  pu po cl  erx    ery    dep f  e  err
    vecs.push_back(mk(1, 4, 8'hAA, 4, 1, 0, 0, 0, 8'hAA, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 8'hFF, 4, 1, 0, 0, 0, 8'hAA, 8'hFF, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2, 3, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2, 8'h11, 2, 4, 0, 0, 0, 8'h11, 8'hAA, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2, 2, 1, 0, 0, 8'h11, 8'h11, 1, 0, 0, 0));
    vecs.push_back(mk(1, 2, 8'h22, 2, 1, 0, 0, 0, 8'h22, 8'hFF, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2, 4, 0, 1, 0, 8'h11, 8'hAA, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2, 1, 0, 1, 0, 8'h11, 8'hFF, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 2, 1, 0, 0, 1, 8'h11, 8'hFF, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2, 4, 1, 0, 0, 8'h11, 8'hAA, 1, 0, 0, 0));
    vecs.push_back(mk(1, 3, 8'h05, 3, 2, 0, 0, 0, 8'h05, 8'h11, 1, 0, 0, 0));
    vecs.push_back(mk(1, 3, 8'h09, 3, 2, 1, 0, 0, 8'h09, 8'h11, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3, 4, 1, 0, 0, 8'h09, 8'hAA, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3, 1, 1, 0, 0, 8'h09, 8'hFF, 4, 1, 0, 0));
    vecs.push_back(mk(1, 5, 8'h5A, 5, 3, 1, 0, 0, 8'h5A, 8'h09, 4, 1, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 5, 3, 0, 0, 1, 8'h5A, 8'h09, 4, 1, 0, 0));
    vecs.push_back(mk(1, 3, 8'h33, 3, 5, 0, 0, 0, 8'h33, 8'h5A, 4, 1, 0, 0));
    vecs.push_back(mk(1, 3, 8'h7E, 3, 5, 0, 1, 0, 8'h7E, 8'h00, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3, 2, 0, 1, 0, 8'h09, 8'h11, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3, 4, 0, 1, 0, 8'h05, 8'hAA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3, 4, 1, 1, 0, 8'h05, 8'hAA, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3, 4, 1, 1, 1, 8'h05, 8'hAA, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3, 4, 0, 0, 1, 8'h05, 8'hAA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 8'hFF, 0, 4, 1, 0, 0, R0V,   8'hAA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, R0V,   8'hFF, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 2, 1, 0, 0, R0V,   8'h11, 3, 0, 0, 0));

    // Reset state.
    idle();
    in_rx_selector = '0; in_ry_selector = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_flags("reset", 0, 3'd0, 1'b0, 1'b1, 1'b0);
    check_all_zero("reset_read");
    rst_n = 1'b1;
    @(negedge clk);

    // Table: inputs held across one rising edge, outputs sampled 1 ns later.
    for (int i = 0; i < vecs.size(); i++) begin
      write_en       = vecs[i].we;
      in_wr_selector = vecs[i].ws;
      in_data        = vecs[i].d;
      in_rx_selector = vecs[i].rx;
      in_ry_selector = vecs[i].ry;
      ctx_push       = vecs[i].push;
      ctx_pop        = vecs[i].pop;
      err_clr        = vecs[i].clr;
      @(posedge clk);
      #1;
      chk("rx", i + 1, 32'(out_rx_data), 32'(vecs[i].erx));
      chk("ry", i + 1, 32'(out_ry_data), 32'(vecs[i].ery));
      check_flags("vec", i + 1, vecs[i].edep, vecs[i].efull, vecs[i].eempty, vecs[i].eerr);
      idle();
    end

    // Asynchronous reset at depth 3, asserted while clk is high between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_flags("async_rst", 100, 3'd0, 1'b0, 1'b1, 1'b0);
    check_all_zero("async_rst_read");
    @(negedge clk);
    rst_n = 1'b1;

    // After reset: popping the now-empty stack is misuse, registers stay 0.
    ctx_pop = 1'b1; in_rx_selector = 3'd4; in_ry_selector = 3'd1;
    @(posedge clk);
    #1;
    chk("post_rst_pop_rx", 101, 32'(out_rx_data), 32'h0);
    chk("post_rst_pop_ry", 101, 32'(out_ry_data), 32'h0);
    check_flags("post_rst_pop", 101, 3'd0, 1'b0, 1'b1, 1'b1);
    idle();

    // Write to r0 after reset: hardwired zero when the feature is built in.
    write_en = 1'b1; in_wr_selector = 3'd0; in_data = 8'hFF; err_clr = 1'b1;
    in_rx_selector = 3'd0; in_ry_selector = 3'd0;
    @(posedge clk);
    #1;
    chk("r0_write_rx", 102, 32'(out_rx_data), 32'(R0V));
    chk("r0_write_ry", 102, 32'(out_ry_data), 32'(R0V));
    chk("r0_write_err", 102, 32'(out_err), 32'h0);
    idle();

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
